// File: rtl/boy_pkg.sv
// Shared types and constants for the boy sprite path (controller and ROMs).
package boy_pkg;

  typedef enum logic [1:0] {
    STAND  = 2'd0,
    WALK_R = 2'd1,
    WALK_L = 2'd2
  } boy_state_t;

  localparam logic [2:0] FS_STAND = 3'd0;
  localparam logic [2:0] FS_R_A   = 3'd1;
  localparam logic [2:0] FS_R_B   = 3'd2;
  localparam logic [2:0] FS_L_A   = 3'd3;
  localparam logic [2:0] FS_L_B   = 3'd4;

  localparam int BOY_SPRITE_W = 20;
  localparam int BOY_SPRITE_H = 40;

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the vsync level into the Clk domain and emits a one-cycle tick per rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign tick = r_sync2 & ~r_hist;

endmodule

// File: rtl/boy_sprite_ctrl.sv
// Boy sprite ROM address / window flag generator plus per-frame walk animation FSM.
module boy_sprite_ctrl
  import boy_pkg::*;
#(
  parameter int SPRITE_W        = BOY_SPRITE_W,
  parameter int SPRITE_H        = BOY_SPRITE_H,
  parameter int FRAMES_PER_STEP = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  BoyX,
  input  logic [9:0]  BoyY,
  input  logic        move_left,
  input  logic        move_right,
  output logic [10:0] read_address,
  output logic        boy_on,
  output logic [2:0]  frame_sel
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAMES_PER_STEP - 1);

  // ---------------- pixel path ----------------
  logic [10:0] w_dx, w_dy, w_bx, w_by;
  logic [10:0] w_x_end, w_y_end;
  logic        w_on;
  logic [9:0]  w_col, w_row;
  logic [10:0] w_row11, w_row_scaled, w_addr;

  assign w_dx    = {1'b0, DrawX};
  assign w_dy    = {1'b0, DrawY};
  assign w_bx    = {1'b0, BoyX};
  assign w_by    = {1'b0, BoyY};
  // 11-bit ends so a sprite near column/row 1023 cannot wrap back to 0.
  assign w_x_end = w_bx + 11'(SPRITE_W);
  assign w_y_end = w_by + 11'(SPRITE_H);
  assign w_on    = (w_dx >= w_bx) & (w_dx < w_x_end) & (w_dy >= w_by) & (w_dy < w_y_end);

  assign w_col   = DrawX - BoyX;
  assign w_row   = DrawY - BoyY;
  assign w_row11 = {1'b0, w_row};

  generate
    if (SPRITE_W == 20) begin : g_w20
      assign w_row_scaled = (w_row11 << 4) + (w_row11 << 2);
    end else begin : g_wgen
      assign w_row_scaled = w_row11 * 11'(SPRITE_W);
    end
  endgenerate

  // Difference bits are meaningless outside the window, so the address is forced to 0 there.
  assign w_addr = w_on ? (w_row_scaled + {1'b0, w_col}) : 11'd0;

  // One-cycle pixel pipeline, aligned with the colour mapper's registered DrawX.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= 11'd0;
      boy_on       <= 1'b0;
    end else begin
      read_address <= w_addr;
      boy_on       <= w_on;
    end
  end

  // ---------------- animation ----------------
  logic w_tick;

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (w_tick)
  );

  boy_state_t    r_state, w_state_nxt, w_target;
  logic          r_phase, w_phase_nxt;
  logic [CW-1:0] r_step_cnt, w_step_nxt;
  logic [2:0]    w_fs_nxt;

  // State, walk timing and registered frame_sel; all advance only on tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= STAND;
      r_phase    <= 1'b0;
      r_step_cnt <= '0;
      frame_sel  <= FS_STAND;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_step_cnt <= w_step_nxt;
      frame_sel  <= w_fs_nxt;
    end
  end

  // Next-state and frame select; keys are only looked at on the frame tick.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_step_nxt  = r_step_cnt;
    w_fs_nxt    = frame_sel;
    w_target    = STAND;
    if (move_right && !move_left)      w_target = WALK_R;
    else if (move_left && !move_right) w_target = WALK_L;

    if (w_tick) begin
      w_state_nxt = w_target;
      if (w_target == STAND || w_target != r_state) begin
        w_phase_nxt = 1'b0;
        w_step_nxt  = '0;
      end else if (r_step_cnt == CNT_MAX) begin
        w_phase_nxt = ~r_phase;
        w_step_nxt  = '0;
      end else begin
        w_step_nxt  = r_step_cnt + 1'b1;
      end

      case (w_target)
        WALK_R:  w_fs_nxt = w_phase_nxt ? FS_R_B : FS_R_A;
        WALK_L:  w_fs_nxt = w_phase_nxt ? FS_L_B : FS_L_A;
        default: w_fs_nxt = FS_STAND;
      endcase
    end
  end

endmodule

// File: tb/tb_boy_sprite_ctrl.sv
// Directed bench for boy_sprite_ctrl: reset, address corners, walk animation, clipping.
module tb_boy_sprite_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  DrawX, DrawY, BoyX, BoyY;
  logic        move_left, move_right;
  logic [10:0] read_address;
  logic        boy_on;
  logic [2:0]  frame_sel;

  int n_chk = 0;
  int n_err = 0;

  boy_sprite_ctrl #(.SPRITE_W(20), .SPRITE_H(40), .FRAMES_PER_STEP(6)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .BoyX         (BoyX),
    .BoyY         (BoyY),
    .move_left    (move_left),
    .move_right   (move_right),
    .read_address (read_address),
    .boy_on       (boy_on),
    .frame_sel    (frame_sel)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One frame_clk pulse; frame_sel has settled by the time the high phase ends.
  task automatic frame_tick();
    frame_clk = 1'b1;
    repeat (4) step();
    frame_clk = 1'b0;
    repeat (3) step();
  endtask

  task automatic pix(input string tag, input logic [9:0] dx, input logic [9:0] dy,
                     input logic [9:0] bx, input logic [9:0] by,
                     input logic exp_on, input logic [10:0] exp_addr);
    DrawX = dx; DrawY = dy; BoyX = bx; BoyY = by;
    step();
    chk({tag, ".on"},   boy_on,       exp_on);
    chk({tag, ".addr"}, read_address, exp_addr);
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; move_left = 1'b0; move_right = 1'b0;
    DrawX = '0; DrawY = '0; BoyX = '0; BoyY = '0;
    #1;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      DrawX = 10'($urandom); DrawY = 10'($urandom);
      BoyX  = 10'($urandom); BoyY  = 10'($urandom);
      move_left = 1'($urandom); move_right = 1'($urandom);
      frame_clk = 1'($urandom);
      step();
      chk("rst.addr", read_address, 0);
      chk("rst.on",   boy_on,       0);
      chk("rst.fs",   frame_sel,    0);
    end
    frame_clk = 1'b0; move_left = 1'b0; move_right = 1'b0;
    Reset = 1'b0;
    repeat (4) step();

    // Address corners
    pix("in",      105, 210, 100, 200, 1'b1, 11'd205);
    pix("last",    119, 239, 100, 200, 1'b1, 11'd799);
    pix("first",   100, 200, 100, 200, 1'b1, 11'd0);
    pix("xright",  120, 239, 100, 200, 1'b0, 11'd0);
    pix("xleft",    99, 200, 100, 200, 1'b0, 11'd0);
    pix("ybelow",  110, 240, 100, 200, 1'b0, 11'd0);
    chk("idle.fs", frame_sel, 0);

    // Walk right
    move_right = 1'b1;
    frame_tick();
    chk("wr.t1", frame_sel, 1);
    repeat (10) step();
    chk("wr.hold", frame_sel, 1);
    for (int i = 0; i < 5; i++) begin
      frame_tick();
      chk("wr.a", frame_sel, 1);
    end
    frame_tick();
    chk("wr.t7", frame_sel, 2);
    for (int i = 0; i < 5; i++) begin
      frame_tick();
      chk("wr.b", frame_sel, 2);
    end
    frame_tick();
    chk("wr.t13", frame_sel, 1);
    repeat (6) frame_tick();
    chk("wr.t19", frame_sel, 2);

    // Reversal from phase 1, then both keys
    move_right = 1'b0; move_left = 1'b1;
    repeat (5) step();
    chk("rev.pre", frame_sel, 2);
    frame_tick();
    chk("rev.l", frame_sel, 3);
    move_right = 1'b1;
    frame_tick();
    chk("both", frame_sel, 0);

    // Key pulse with no frame edge
    move_right = 1'b0; move_left = 1'b0;
    frame_tick();
    move_right = 1'b1;
    repeat (3) step();
    move_right = 1'b0;
    repeat (10) step();
    chk("pulse", frame_sel, 0);
    frame_tick();
    chk("pulse.t", frame_sel, 0);

    // Reset mid-walk
    move_left = 1'b1;
    frame_tick();
    chk("wl.t1", frame_sel, 3);
    pix("prerst", 105, 210, 100, 200, 1'b1, 11'd205);
    Reset = 1'b1;
    step();
    chk("midrst.fs",   frame_sel,    0);
    chk("midrst.on",   boy_on,       0);
    chk("midrst.addr", read_address, 0);
    Reset = 1'b0;
    step();
    chk("postrst.fs", frame_sel, 0);
    move_left = 1'b0;
    repeat (3) step();

    // Edge clipping
    pix("clip.in",  639, 51, 630, 50, 1'b1, 11'd29);
    pix("clip.x0",    0, 51, 630, 50, 1'b0, 11'd0);
    pix("clip.hi", 1023, 51, 1010, 50, 1'b1, 11'd33);
    pix("clip.wrap",  2, 51, 1010, 50, 1'b0, 11'd0);

    // frame_clk already high when reset drops: tick lands on the third edge
    Reset = 1'b1; frame_clk = 1'b1; move_right = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    step();
    chk("rel.e1", frame_sel, 0);
    step();
    chk("rel.e2", frame_sel, 0);
    step();
    chk("rel.e3", frame_sel, 1);
    repeat (5) step();
    chk("rel.hold", frame_sel, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
